// File: rtl/phase_ramp_ctrl.sv
// rtl/phase_ramp_ctrl.sv - loop sequencer for the gyro phase-ramp generator
//
// Runs the modulation period counter, emits the square-wave modulation and the
// per-period ramp trigger, integrates demodulated rate error into the ramp step
// and sequences IDLE -> OPEN -> CLOSE (-> FAULT on sustained saturation).
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_en             loop enable; low returns to IDLE and clears the loop state
//   i_half_period    clocks per modulation half period (min 2), latched leaving IDLE
//   i_mod_amp        signed modulation amplitude
//   i_settle         open-loop periods before closing (min 1), latched leaving IDLE
//   i_err/i_err_vld  signed demodulated error sample and its strobe
//   i_gain_sh        integrator gain as an arithmetic right shift of i_err
//   o_trig           one-cycle ramp trigger per period
//   o_mod            +amp / -amp / 0
//   o_step           signed ramp step, updated at period start
//   o_fb_on          feedback enable
//   o_state          0 IDLE, 1 OPEN, 2 CLOSE, 3 FAULT
//   o_sat            high in FAULT
module phase_ramp_ctrl #(
    parameter int OUTPUT_BIT = 16,
    parameter int ERR_BIT    = 24,
    parameter int FRAC_BIT   = 8,
    parameter int CNT_BIT    = 16,
    parameter int SAT_LIMIT  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic [CNT_BIT-1:0]    i_half_period,
    input  logic [OUTPUT_BIT-1:0] i_mod_amp,
    input  logic [CNT_BIT-1:0]    i_settle,
    input  logic [ERR_BIT-1:0]    i_err,
    input  logic                  i_err_vld,
    input  logic [4:0]            i_gain_sh,
    output logic                  o_trig,
    output logic [OUTPUT_BIT-1:0] o_mod,
    output logic [OUTPUT_BIT-1:0] o_step,
    output logic                  o_fb_on,
    output logic [1:0]            o_state,
    output logic                  o_sat
);

    localparam int ACC_BIT = OUTPUT_BIT + FRAC_BIT;
    localparam int SUM_W   = ((ACC_BIT > ERR_BIT) ? ACC_BIT : ERR_BIT) + 1;
    localparam int SAT_W   = $clog2(SAT_LIMIT + 1);

    localparam logic signed [ACC_BIT-1:0] ACC_MAX = {1'b0, {(ACC_BIT-1){1'b1}}};
    localparam logic signed [ACC_BIT-1:0] ACC_MIN = {1'b1, {(ACC_BIT-1){1'b0}}};
    localparam logic signed [SUM_W-1:0]   SUM_MAX = {{(SUM_W-ACC_BIT+1){1'b0}}, {(ACC_BIT-1){1'b1}}};
    localparam logic signed [SUM_W-1:0]   SUM_MIN = {{(SUM_W-ACC_BIT+1){1'b1}}, {(ACC_BIT-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t                     state;
    logic [CNT_BIT:0]           cnt;
    logic [CNT_BIT-1:0]         h_reg;
    logic [CNT_BIT-1:0]         settle_reg;
    logic [CNT_BIT-1:0]         trig_cnt;
    logic [SAT_W-1:0]           sat_cnt;
    logic signed [ACC_BIT-1:0]  acc;

    logic [CNT_BIT:0]           cnt_last;
    logic signed [SUM_W-1:0]    err_ext;
    logic signed [SUM_W-1:0]    err_sh;
    logic signed [SUM_W-1:0]    acc_ext;
    logic signed [SUM_W-1:0]    sum;
    logic signed [ACC_BIT-1:0]  acc_next;
    logic                       sat_hit;

    assign o_state  = state;
    assign cnt_last = {h_reg, 1'b0} - (CNT_BIT+1)'(1);

    // Sum is one bit wider than either operand so the clamp sees the true result.
    always_comb begin
        err_ext  = {{(SUM_W-ERR_BIT){i_err[ERR_BIT-1]}}, i_err};
        err_sh   = err_ext >>> i_gain_sh;
        acc_ext  = {{(SUM_W-ACC_BIT){acc[ACC_BIT-1]}}, acc};
        sum      = acc_ext + err_sh;
        acc_next = sum[ACC_BIT-1:0];
        if (sum > SUM_MAX) begin
            acc_next = ACC_MAX;
        end else if (sum < SUM_MIN) begin
            acc_next = ACC_MIN;
        end
        sat_hit  = (sum >= SUM_MAX) || (sum <= SUM_MIN);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            h_reg      <= '0;
            settle_reg <= '0;
            trig_cnt   <= '0;
            sat_cnt    <= '0;
            acc        <= '0;
            o_trig     <= 1'b0;
            o_mod      <= '0;
            o_step     <= '0;
            o_fb_on    <= 1'b0;
            o_sat      <= 1'b0;
        end else if (!i_en) begin
            // Disable overrides every other event, including a coincident sample.
            state    <= IDLE;
            cnt      <= '0;
            trig_cnt <= '0;
            sat_cnt  <= '0;
            acc      <= '0;
            o_trig   <= 1'b0;
            o_mod    <= '0;
            o_step   <= '0;
            o_fb_on  <= 1'b0;
            o_sat    <= 1'b0;
        end else if (state == IDLE) begin
            state      <= OPEN;
            h_reg      <= (i_half_period < CNT_BIT'(2)) ? CNT_BIT'(2) : i_half_period;
            settle_reg <= (i_settle == '0) ? CNT_BIT'(1) : i_settle;
        end else begin
            // Outputs are decoded from the pre-increment count, so they lag cnt by one clock.
            cnt    <= (cnt == cnt_last) ? '0 : cnt + (CNT_BIT+1)'(1);
            o_mod  <= (cnt < {1'b0, h_reg}) ? i_mod_amp : -i_mod_amp;
            o_trig <= (cnt == cnt_last);
            case (state)
                OPEN: begin
                    // Counting the registered trigger puts CLOSE one cycle after that pulse.
                    if (o_trig) begin
                        if (({1'b0, trig_cnt} + (CNT_BIT+1)'(1)) >= {1'b0, settle_reg}) begin
                            state   <= CLOSE;
                            o_fb_on <= 1'b1;
                        end else begin
                            trig_cnt <= trig_cnt + CNT_BIT'(1);
                        end
                    end
                end
                CLOSE: begin
                    if (sat_cnt == SAT_W'(SAT_LIMIT)) begin
                        state   <= FAULT;
                        o_fb_on <= 1'b0;
                        o_sat   <= 1'b1;
                        o_step  <= '0;
                    end else begin
                        if (i_err_vld) begin
                            acc     <= acc_next;
                            sat_cnt <= sat_hit ? sat_cnt + SAT_W'(1) : '0;
                        end
                        // Step takes the accumulator as it stood before this clock's sample.
                        if (cnt == '0) begin
                            o_step <= acc[ACC_BIT-1:FRAC_BIT];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_phase_ramp_ctrl.sv
// tb/tb_phase_ramp_ctrl.sv - self-checking bench for phase_ramp_ctrl
module tb_phase_ramp_ctrl;

    localparam int OB = 16;
    localparam int EB = 24;
    localparam int FB = 8;
    localparam int CB = 16;
    localparam int SL = 8;
    localparam int AB = OB + FB;
    localparam longint AMAX = (longint'(1) << (AB-1)) - 1;
    localparam longint AMIN = -(longint'(1) << (AB-1));
    localparam logic [15:0] P = 16'd1000;
    localparam logic [15:0] N = 16'hFC18;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [CB-1:0] half = 16'd4;
    logic [OB-1:0] amp = 16'd1000;
    logic [CB-1:0] settle = 16'd5;
    logic [EB-1:0] err = '0;
    logic          err_vld = 1'b0;
    logic [4:0]    gain = '0;
    logic          o_trig;
    logic [OB-1:0] o_mod;
    logic [OB-1:0] o_step;
    logic          o_fb_on;
    logic [1:0]    o_state;
    logic          o_sat;

    phase_ramp_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_half_period(half),
        .i_mod_amp(amp), .i_settle(settle), .i_err(err), .i_err_vld(err_vld),
        .i_gain_sh(gain), .o_trig(o_trig), .o_mod(o_mod), .o_step(o_step),
        .o_fb_on(o_fb_on), .o_state(o_state), .o_sat(o_sat)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: time since loop start, period arithmetic, integer accumulator.
    int     m_state;
    longint m_age, m_h, m_s, m_trigs, m_acc, m_sat;
    int     m_mod, m_step;
    bit     m_trig, m_fb, m_satf;

    function automatic void m_reset();
        m_state = 0; m_age = 0; m_trigs = 0; m_acc = 0; m_sat = 0;
        m_mod = 0; m_step = 0; m_trig = 0; m_fb = 0; m_satf = 0;
    endfunction

    function automatic void m_edge();
        longint a, per, e;
        bit     pt;
        if (!en) begin
            m_reset();
        end else if (m_state == 0) begin
            m_state = 1; m_age = 0; m_trigs = 0;
            m_h = (half < 2) ? 2 : longint'(half);
            m_s = (settle < 1) ? 1 : longint'(settle);
        end else begin
            a = m_age; m_age++; per = 2 * m_h; pt = m_trig;
            m_mod  = ((a % per) < m_h) ? int'($signed(amp)) : -int'($signed(amp));
            m_trig = ((a % per) == per - 1);
            if (m_state == 1) begin
                if (pt) begin
                    m_trigs++;
                    if (m_trigs >= m_s) begin m_state = 2; m_fb = 1; end
                end
            end else if (m_state == 2) begin
                if (m_sat == SL) begin
                    m_state = 3; m_fb = 0; m_satf = 1; m_step = 0;
                end else begin
                    if ((a % per) == 0) m_step = int'(m_acc >>> FB);
                    if (err_vld) begin
                        e = longint'($signed(err)) >>> gain;
                        m_acc = m_acc + e;
                        if (m_acc > AMAX) m_acc = AMAX;
                        if (m_acc < AMIN) m_acc = AMIN;
                        m_sat = (m_acc == AMAX || m_acc == AMIN) ? m_sat + 1 : 0;
                    end
                end
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, got, exp);
        end
    endtask

    function automatic logic [36:0] dut_vec();
        return {o_state, o_sat, o_fb_on, o_trig, o_mod, o_step};
    endfunction

    function automatic logic [36:0] mdl_vec();
        return {2'(m_state), m_satf, m_fb, m_trig, 16'(m_mod), 16'(m_step)};
    endfunction

    task automatic cyc();
        m_edge();
        @(posedge clk);
        @(negedge clk);
        chk("model", 64'(dut_vec()), 64'(mdl_vec()));
    endtask

    typedef struct {
        logic        en;
        logic [15:0] mod;
        logic        trig;
        logic [1:0]  st;
    } vec_t;
    vec_t tbl[20];

    task automatic run_tbl();
        for (int i = 0; i < 20; i++) begin
            en = tbl[i].en;
            cyc();
            chk("tbl_row", 64'({o_state, o_trig, o_mod}), 64'({tbl[i].st, tbl[i].trig, tbl[i].mod}));
        end
    endtask

    initial begin
        // H=4, amp=1000, settle=5: row 0 is the enabling edge.
        tbl[0]  = '{1'b1, 16'd0, 1'b0, 2'd1};
        tbl[1]  = '{1'b1, P, 1'b0, 2'd1};
        tbl[2]  = '{1'b1, P, 1'b0, 2'd1};
        tbl[3]  = '{1'b1, P, 1'b0, 2'd1};
        tbl[4]  = '{1'b1, P, 1'b0, 2'd1};
        tbl[5]  = '{1'b1, N, 1'b0, 2'd1};
        tbl[6]  = '{1'b1, N, 1'b0, 2'd1};
        tbl[7]  = '{1'b1, N, 1'b0, 2'd1};
        tbl[8]  = '{1'b1, N, 1'b1, 2'd1};
        tbl[9]  = '{1'b1, P, 1'b0, 2'd1};
        tbl[10] = '{1'b1, P, 1'b0, 2'd1};
        tbl[11] = '{1'b1, P, 1'b0, 2'd1};
        tbl[12] = '{1'b1, P, 1'b0, 2'd1};
        tbl[13] = '{1'b1, N, 1'b0, 2'd1};
        tbl[14] = '{1'b1, N, 1'b0, 2'd1};
        tbl[15] = '{1'b1, N, 1'b0, 2'd1};
        tbl[16] = '{1'b1, N, 1'b1, 2'd1};
        tbl[17] = '{1'b0, 16'd0, 1'b0, 2'd0};
        tbl[18] = '{1'b1, 16'd0, 1'b0, 2'd1};
        tbl[19] = '{1'b1, P, 1'b0, 2'd1};

        m_reset();
        repeat (2) @(negedge clk);
        chk("reset", 64'(dut_vec()), 64'd0);
        rst_n = 1'b1;

        // Basic modulation / trigger timing
        run_tbl();

        // settle=3: CLOSE one cycle after the third trigger
        en = 1'b0; cyc();
        settle = 16'd3; en = 1'b1;
        for (int r = 0; r <= 25; r++) begin
            cyc();
            if (r == 24) chk("settle3_trig", 64'({o_state, o_trig}), 64'({2'd1, 1'b1}));
            if (r == 25) chk("settle3_close", 64'({o_state, o_fb_on}), 64'({2'd2, 1'b1}));
        end

        // settle=0 closes after first trigger; integration; saturation fault
        en = 1'b0; cyc();
        settle = 16'd0; en = 1'b1;
        for (int r = 0; r <= 104; r++) begin
            if (r < 44) begin gain = 5'd2; err = 24'd1024; end
            else begin gain = 5'd0; err = 24'h7FFFFF; end
            err_vld = (r >= 12) && (r % 8 == 4);
            cyc();
            if (r == 8)   chk("settle0_trig", 64'({o_state, o_trig}), 64'({2'd1, 1'b1}));
            if (r == 9)   chk("settle0_close", 64'({o_state, o_fb_on}), 64'({2'd2, 1'b1}));
            if (r == 16)  chk("step_p0", 64'({o_trig, o_step}), 64'({1'b1, 16'd0}));
            if (r == 17)  chk("step_p1", 64'(o_step), 64'd1);
            if (r == 24)  chk("step_hold", 64'({o_trig, o_step}), 64'({1'b1, 16'd1}));
            if (r == 25)  chk("step_p2", 64'(o_step), 64'd2);
            if (r == 33)  chk("step_p3", 64'(o_step), 64'd3);
            if (r == 57)  chk("step_clamp", 64'(o_step), 64'h7FFF);
            if (r == 100) chk("pre_fault", 64'(o_state), 64'd2);
            if (r == 101) chk("fault", 64'({o_state, o_sat, o_fb_on, o_step}), 64'({2'd3, 1'b1, 1'b0, 16'd0}));
        end
        err_vld = 1'b0;
        en = 1'b0; cyc();
        chk("fault_exit", 64'(dut_vec()), 64'd0);

        // en dropped with coincident err_vld, then H change mid-run
        half = 16'd4; gain = 5'd2; err = 24'd1024; en = 1'b1;
        for (int r = 0; r <= 14; r++) begin
            err_vld = (r == 12) || (r == 14);
            en = (r != 14);
            cyc();
            if (r == 14) chk("en_drop", 64'(dut_vec()), 64'd0);
        end
        err_vld = 1'b0; en = 1'b1;
        for (int r = 0; r <= 17; r++) begin
            if (r == 3) half = 16'd6;
            cyc();
            if (r == 8)  chk("h_ignored", 64'(o_trig), 64'd1);
            if (r == 17) chk("acc_cleared", 64'({o_state, o_step}), 64'({2'd2, 16'd0}));
        end
        en = 1'b0; cyc();
        en = 1'b1;
        for (int r = 0; r <= 12; r++) begin
            cyc();
            if (r == 8)  chk("h6_no_trig", 64'(o_trig), 64'd0);
            if (r == 12) chk("h6_trig", 64'(o_trig), 64'd1);
        end

        // Async reset mid-period, then same timing as the basic run
        repeat (3) cyc();
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 64'(dut_vec()), 64'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        half = 16'd4; amp = 16'd1000; settle = 16'd5; en = 1'b0;
        run_tbl();

        // Randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(0, 150) != 0);
            if ($urandom_range(0, 40) == 0) half = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 40) == 0) settle = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 60) == 0) amp = 16'($urandom);
            if ($urandom_range(0, 30) == 0) gain = 5'($urandom_range(0, 14));
            err = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($signed(12'($urandom)));
            err_vld = ($urandom_range(0, 4) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
